// File: rtl/recv_img.sv
// UART image receiver: deserialises 8N1 bytes with an oversampling receiver
// and writes each byte as one pixel into a sequentially addressed frame BRAM.
module recv_img #(
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int BRAM_LENGTH     = 4096,
    parameter int ADDR_WIDTH      = 14
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rx,
    input  logic                  restart_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [7:0]            pixel_out,
    output logic                  we_out,
    output logic                  busy,
    output logic                  full_image_received,
    output logic                  frame_err,
    output logic [7:0]            err_count,
    output logic [1:0]            out_state
);

    localparam int CW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BRAM_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic            rx_meta_reg;
    logic            rx_s_reg;
    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            stop_err_reg, stop_err_next;
    logic            byte_done;
    logic            bad_stop;

    logic [ADDR_WIDTH-1:0] index_reg;
    logic [ADDR_WIDTH-1:0] address_reg;
    logic [7:0]            pixel_reg;
    logic                  we_reg;
    logic                  busy_reg;
    logic                  last_reg;
    logic                  full_reg;
    logic                  ferr_reg;
    logic [7:0]            err_cnt_reg;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            stop_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            stop_err_reg <= stop_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        stop_err_next = stop_err_reg;
        byte_done     = 1'b0;
        bad_stop      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rx_s_reg) begin
                    state_next = S_START;
                    cnt_next   = '0;
                end
            end
            S_START: begin
                if (cnt_reg == HALF_M1) begin
                    cnt_next = '0;
                    if (!rx_s_reg) begin
                        state_next = S_DATA;
                        bit_next   = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_reg == FULL_M1) begin
                    cnt_next   = '0;
                    shift_next = {rx_s_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_STOP: begin
                // After a bad stop bit, park here until the line returns high.
                if (stop_err_reg) begin
                    if (rx_s_reg) begin
                        state_next    = S_IDLE;
                        stop_err_next = 1'b0;
                    end
                end else if (cnt_reg == FULL_M1) begin
                    cnt_next = '0;
                    if (rx_s_reg) begin
                        byte_done  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        bad_stop      = 1'b1;
                        stop_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Pixel write port and image bookkeeping; restart always beats increment.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            index_reg   <= '0;
            address_reg <= '0;
            pixel_reg   <= '0;
            we_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            last_reg    <= 1'b0;
            full_reg    <= 1'b0;
        end else begin
            we_reg   <= byte_done;
            last_reg <= byte_done && (index_reg == LAST_IDX) && !restart_in;
            full_reg <= last_reg && !restart_in;
            if (byte_done) begin
                address_reg <= index_reg;
                pixel_reg   <= shift_reg;
            end
            if (restart_in) begin
                index_reg <= '0;
            end else if (byte_done) begin
                index_reg <= (index_reg == LAST_IDX) ? '0 : index_reg + 1'b1;
            end
            if (restart_in || last_reg) begin
                busy_reg <= 1'b0;
            end else if (byte_done && (index_reg == '0)) begin
                busy_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            ferr_reg    <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            ferr_reg <= bad_stop;
            if (bad_stop && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign address             = address_reg;
    assign pixel_out           = pixel_reg;
    assign we_out              = we_reg;
    assign busy                = busy_reg;
    assign full_image_received = full_reg;
    assign frame_err           = ferr_reg;
    assign err_count           = err_cnt_reg;
    assign out_state           = state_reg;

endmodule

// File: tb/tb_recv_img.sv
// Scoreboard bench for recv_img: UART bytes are driven serially, expected
// pixel writes are queued at send time and matched against observed writes.
module tb_recv_img;

    localparam int CPB     = 50;
    localparam int LEN     = 4;
    localparam int AW      = 14;
    localparam int EXP_LAT = 3 + CPB / 2 + 9 * CPB;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          rx;
    logic          restart_in;
    logic [AW-1:0] address;
    logic [7:0]    pixel_out;
    logic          we_out;
    logic          busy;
    logic          full_image_received;
    logic          frame_err;
    logic [7:0]    err_count;
    logic [1:0]    out_state;

    always #5 clk = ~clk;

    recv_img #(
        .CLOCKS_PER_BAUD(CPB),
        .BRAM_LENGTH(LEN),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .rx(rx),
        .restart_in(restart_in),
        .address(address),
        .pixel_out(pixel_out),
        .we_out(we_out),
        .busy(busy),
        .full_image_received(full_image_received),
        .frame_err(frame_err),
        .err_count(err_count),
        .out_state(out_state)
    );

    int errors = 0;
    int checks = 0;
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] obs_q[$];
    int exp_index = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int wr_cnt = 0;
    int full_cnt = 0;
    int full_bad = 0;
    int ferr_cnt = 0;
    logic prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture observed DUT events; comparison happens in the test tasks.
    always @(negedge clk) begin
        if (!rst_in) begin
            prev_last = 1'b0;
        end else begin
            if (we_out) begin
                obs_q.push_back({address, pixel_out});
                wr_cnt++;
                last_we_cyc = cyc;
            end
            if (full_image_received) begin
                full_cnt++;
                if (!prev_last || busy !== 1'b0) full_bad++;
            end
            if (frame_err) ferr_cnt++;
            prev_last = we_out && (address == AW'(LEN - 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_expect(input logic [7:0] d);
        exp_q.push_back({AW'(exp_index), d});
        exp_index = (exp_index + 1) % LEN;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_val, input int stop_bits);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop_val;
        tick(CPB * stop_bits);
        rx = 1'b1;
    endtask

    task automatic pulse_restart();
        restart_in = 1'b1;
        tick(1);
        restart_in = 1'b0;
        exp_index = 0;
    endtask

    task automatic test_reset();
        logic [35:0] v;
        int w0;
        rst_in = 1'b0; rx = 1'b1; restart_in = 1'b0;
        tick(5);
        rst_in = 1'b1;
        tick(2);
        rx = 1'b0;
        tick(200);
        checks++;
        if (out_state !== 2'd2) begin
            errors++; $display("FAIL reset_midbyte_state: got %0d, required 2", out_state);
        end
        #2 rst_in = 1'b0;
        #1;
        v = {address, pixel_out, we_out, busy, full_image_received, frame_err, err_count, out_state};
        checks++;
        if (v !== 36'd0) begin
            errors++; $display("FAIL reset_async_outputs: got %h, required 0", v);
        end
        rx = 1'b1;
        tick(5);
        rst_in = 1'b1;
        w0 = wr_cnt;
        tick(2000);
        v = {address, pixel_out, we_out, busy, full_image_received, frame_err, err_count, out_state};
        checks++;
        if (v !== 36'd0 || wr_cnt != w0) begin
            errors++; $display("FAIL reset_idle: got outputs=%h writes=%0d, required 0 and 0", v, wr_cnt - w0);
        end
        $display("reset: idle outputs=%h writes=%0d", v, wr_cnt - w0);
    endtask

    task automatic test_single_byte();
        int t0, w0;
        logic [AW+7:0] o, e;
        w0 = wr_cnt;
        push_expect(8'hA5);
        t0 = cyc;
        send_byte(8'hA5, 1'b1, 1);
        tick(2);
        checks++;
        if (wr_cnt - w0 != 1) begin
            errors++; $display("FAIL single_write_count: got %0d, required 1", wr_cnt - w0);
        end
        checks++;
        if (last_we_cyc - t0 != EXP_LAT) begin
            errors++; $display("FAIL single_latency: got %0d, required %0d", last_we_cyc - t0, EXP_LAT);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_busy: got %b, required 1", busy);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL single_unexpected_write: got addr=%0d data=%h, required none", o[AW+7:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL single_write: got addr=%0d data=%h, required addr=%0d data=%h", o[AW+7:8], o[7:0], e[AW+7:8], e[7:0]);
                end else $display("write addr=%0d data=%h", o[AW+7:8], o[7:0]);
            end
        end
    endtask

    task automatic test_full_image();
        int f0;
        logic [AW+7:0] o, e;
        pulse_restart();
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL full_busy_after_restart: got %b, required 0", busy);
        end
        f0 = full_cnt;
        for (int i = 1; i <= 4; i++) begin
            push_expect(8'(i));
            send_byte(8'(i), 1'b1, 1);
        end
        tick(5);
        checks++;
        if (full_cnt - f0 != 1) begin
            errors++; $display("FAIL full_pulse_count: got %0d, required 1", full_cnt - f0);
        end
        checks++;
        if (busy !== 1'b0 || full_bad != 0) begin
            errors++; $display("FAIL full_timing: got busy=%b bad_pulses=%0d, required busy=0 bad_pulses=0", busy, full_bad);
        end
        push_expect(8'h55);
        send_byte(8'h55, 1'b1, 1);
        tick(3);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL full_new_image_busy: got %b, required 1", busy);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL full_unexpected_write: got addr=%0d data=%h, required none", o[AW+7:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL full_write: got addr=%0d data=%h, required addr=%0d data=%h", o[AW+7:8], o[7:0], e[AW+7:8], e[7:0]);
                end else $display("write addr=%0d data=%h", o[AW+7:8], o[7:0]);
            end
        end
    endtask

    task automatic test_frame_err();
        int w0, e0;
        logic [AW+7:0] o, e;
        tick(CPB);
        checks++;
        if (err_count !== 8'd0) begin
            errors++; $display("FAIL ferr_initial_count: got %0d, required 0", err_count);
        end
        w0 = wr_cnt; e0 = ferr_cnt;
        send_byte(8'h3C, 1'b0, 3);
        tick(CPB);
        checks++;
        if (ferr_cnt - e0 != 1 || err_count !== 8'd1) begin
            errors++; $display("FAIL ferr_pulse: got pulses=%0d count=%0d, required pulses=1 count=1", ferr_cnt - e0, err_count);
        end
        checks++;
        if (wr_cnt != w0) begin
            errors++; $display("FAIL ferr_dropped_byte: got %0d writes, required 0", wr_cnt - w0);
        end
        push_expect(8'h7E);
        send_byte(8'h7E, 1'b1, 1);
        tick(3);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL ferr_unexpected_write: got addr=%0d data=%h, required none", o[AW+7:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL ferr_write: got addr=%0d data=%h, required addr=%0d data=%h", o[AW+7:8], o[7:0], e[AW+7:8], e[7:0]);
                end else $display("write addr=%0d data=%h", o[AW+7:8], o[7:0]);
            end
        end
    endtask

    task automatic test_glitch();
        int w0, e0;
        w0 = wr_cnt; e0 = ferr_cnt;
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(4);
        checks++;
        if (out_state !== 2'd1) begin
            errors++; $display("FAIL glitch_start_state: got %0d, required 1", out_state);
        end
        tick(60);
        checks++;
        if (out_state !== 2'd0 || wr_cnt != w0 || ferr_cnt != e0) begin
            errors++; $display("FAIL glitch_reject: got state=%0d writes=%0d ferr=%0d, required 0 0 0", out_state, wr_cnt - w0, ferr_cnt - e0);
        end
        $display("glitch: state=%0d writes=%0d", out_state, wr_cnt - w0);
    endtask

    task automatic test_restart();
        int f0;
        logic [AW+7:0] o, e;
        pulse_restart();
        push_expect(8'hC1); send_byte(8'hC1, 1'b1, 1);
        push_expect(8'hC2); send_byte(8'hC2, 1'b1, 1);
        tick(3);
        pulse_restart();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL restart_busy: got %b, required 0", busy);
        end
        f0 = full_cnt;
        for (int i = 0; i < 4; i++) begin
            push_expect(8'hD0 + 8'(i));
            send_byte(8'hD0 + 8'(i), 1'b1, 1);
        end
        tick(5);
        checks++;
        if (full_cnt - f0 != 1 || full_bad != 0) begin
            errors++; $display("FAIL restart_full: got pulses=%0d bad=%0d, required pulses=1 bad=0", full_cnt - f0, full_bad);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL restart_unexpected_write: got addr=%0d data=%h, required none", o[AW+7:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL restart_write: got addr=%0d data=%h, required addr=%0d data=%h", o[AW+7:8], o[7:0], e[AW+7:8], e[7:0]);
                end else $display("write addr=%0d data=%h", o[AW+7:8], o[7:0]);
            end
        end
    endtask

    task automatic test_restart_on_last();
        int f0;
        logic [AW+7:0] o, e;
        pulse_restart();
        for (int i = 0; i < 3; i++) begin
            push_expect(8'hE0 + 8'(i));
            send_byte(8'hE0 + 8'(i), 1'b1, 1);
        end
        f0 = full_cnt;
        push_expect(8'hEF);
        exp_index = 0;
        fork
            send_byte(8'hEF, 1'b1, 1);
            begin
                tick(EXP_LAT);
                restart_in = 1'b1;
                tick(1);
                restart_in = 1'b0;
            end
        join
        tick(5);
        checks++;
        if (full_cnt != f0 || busy !== 1'b0) begin
            errors++; $display("FAIL restart_last_suppress: got pulses=%0d busy=%b, required 0 and 0", full_cnt - f0, busy);
        end
        push_expect(8'h99);
        send_byte(8'h99, 1'b1, 1);
        tick(3);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL rlast_unexpected_write: got addr=%0d data=%h, required none", o[AW+7:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL rlast_write: got addr=%0d data=%h, required addr=%0d data=%h", o[AW+7:8], o[7:0], e[AW+7:8], e[7:0]);
                end else $display("write addr=%0d data=%h", o[AW+7:8], o[7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int f0, exp_f;
        logic [7:0] d;
        logic [AW+7:0] o, e;
        f0 = full_cnt; exp_f = 0;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            if (exp_index == LEN - 1) exp_f++;
            push_expect(d);
            send_byte(d, 1'b1, 1);
            checks++;
            if (exp_q.size() != obs_q.size()) begin
                errors++; $display("FAIL b2b_write_pending: got %0d observed, required %0d", obs_q.size(), exp_q.size());
            end
        end
        tick(5);
        checks++;
        if (full_cnt - f0 != exp_f || full_bad != 0) begin
            errors++; $display("FAIL b2b_full: got pulses=%0d bad=%0d, required pulses=%0d bad=0", full_cnt - f0, full_bad, exp_f);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL b2b_unexpected_write: got addr=%0d data=%h, required none", o[AW+7:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL b2b_write: got addr=%0d data=%h, required addr=%0d data=%h", o[AW+7:8], o[7:0], e[AW+7:8], e[7:0]);
                end else $display("write addr=%0d data=%h", o[AW+7:8], o[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_full_image();
        test_frame_err();
        test_glitch();
        test_restart();
        test_restart_on_last();
        test_back_to_back();
        tick(10);
        checks++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got expected=%0d observed=%0d left, required 0 and 0", exp_q.size(), obs_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
